freq_ratio_ctrl: RTL and testbench

FREQ_RATIO_CTRL -- requirements
Module: freq_ratio_ctrl

---
 rtl/freq_ratio_ctrl.sv | 118 +++++++++++
 tb/tb_freq_ratio_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_ratio_ctrl.sv
// freq_ratio_ctrl: measures clk2 against clk1 by counting clk2 rising edges
// over a programmable window of clk1 cycles, with saturation and abort.
`timescale 1ns / 1ps
module freq_ratio_ctrl #(
   parameter int CNT_W = 12,
   parameter int WIN_W = 8
) (
   input  logic             clk1,
   input  logic             rst,
   input  logic             clk2,
   input  logic             start,
   input  logic             abort,
   input  logic [WIN_W-1:0] window,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] result,
   output logic             overflow
);
   typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           r_state, w_state_nxt;
   logic             r_tgl, r_sync1, r_sync2, r_sync3;
   logic             w_edge, w_accept, w_done;
   logic [WIN_W-1:0] r_win_cnt;
   logic [CNT_W-1:0] r_edge_cnt, r_result;
   logic             r_ovf, r_ovf_res;

   // A level that flips per edge survives the crossing where a short pulse would not.
   always_ff @(posedge clk2 or posedge rst) begin
      if (rst) r_tgl <= 1'b0;
      else     r_tgl <= ~r_tgl;
   end

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_sync3 <= 1'b0;
      end else begin
         r_sync1 <= r_tgl;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
      end
   end

   assign w_edge   = r_sync2 ^ r_sync3;
   assign w_accept = start & ~abort;

   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   // NOTE: next state is defaulted before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = (window == '0) ? S_DONE : S_CLEAR;
         S_CLEAR: w_state_nxt = abort ? S_IDLE : S_RUN;
         S_RUN: begin
            if (abort)                         w_state_nxt = S_IDLE;
            else if (r_win_cnt == WIN_W'(1))   w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: state here uses <= only; blocking assignments would make the outcome depend on process order.
   always_ff @(posedge clk1 or posedge rst) begin
      if (rst) begin
         r_win_cnt  <= '0;
         r_edge_cnt <= '0;
         r_ovf      <= 1'b0;
         r_result   <= '0;
         r_ovf_res  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_win_cnt <= window;
                  if (window == '0) begin
                     r_edge_cnt <= '0;
                     r_ovf      <= 1'b0;
                  end
               end
            end
            S_CLEAR: begin
               r_edge_cnt <= '0;
               r_ovf      <= 1'b0;
            end
            S_RUN: begin
               r_win_cnt <= r_win_cnt - WIN_W'(1);
               if (w_edge) begin
                  if (r_edge_cnt == CNT_MAX) r_ovf <= 1'b1;
                  else                       r_edge_cnt <= r_edge_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               if (!abort) begin
                  r_result  <= r_edge_cnt;
                  r_ovf_res <= r_ovf;
               end
            end
            default: ;
         endcase
      end
   end

   // Abort in DONE must veto the pulse in that same cycle, so the result view follows w_done.
   assign w_done   = (r_state == S_DONE) && !abort;
   assign done     = w_done;
   assign busy     = (r_state != S_IDLE);
   assign result   = w_done ? r_edge_cnt : r_result;
   assign overflow = w_done ? r_ovf : r_ovf_res;

endmodule

// File: tb/tb_freq_ratio_ctrl.sv
// Bench for freq_ratio_ctrl: table vectors, hand-written corner sequences and
// randomized windows/periods against an arithmetic frequency-ratio model.
`timescale 1ns / 1ps
module tb_freq_ratio_ctrl;
   logic        clk1, clk2a, clk2b, rst, start, abort;
   logic [7:0]  window;
   logic        busy_a, done_a, overflow_a, busy_b, done_b, overflow_b;
   logic [11:0] result_a;
   logic [3:0]  result_b;
   int          n_tests, n_fail;
   int          t2_half  = 20;
   bit          clk2a_en = 1'b1;

   typedef struct {
      int w;
      int t2;
      bit en;
      int exp_lat;
      int exp_res;
      int tol;
   } vec_t;
   vec_t vecs [7];
   int   periods [6] = '{20, 24, 30, 40, 56, 70};

   freq_ratio_ctrl dut_a (
      .clk1(clk1), .rst(rst), .clk2(clk2a), .start(start), .abort(abort), .window(window),
      .busy(busy_a), .done(done_a), .result(result_a), .overflow(overflow_a)
   );

   freq_ratio_ctrl #(.CNT_W(4), .WIN_W(8)) dut_b (
      .clk1(clk1), .rst(rst), .clk2(clk2b), .start(start), .abort(abort), .window(window),
      .busy(busy_b), .done(done_b), .result(result_b), .overflow(overflow_b)
   );

   // clk1 rises on odd ns, both clk2 sources on even ns, so edges never coincide.
   initial begin
      clk1 = 1'b0;
      forever #5 clk1 = ~clk1;
   end

   initial begin
      clk2a = 1'b0;
      #2;
      forever begin
         if (clk2a_en) begin
            clk2a = 1'b1; #(t2_half);
            clk2a = 1'b0; #(t2_half);
         end else begin
            #2;
         end
      end
   end

   initial begin
      clk2b = 1'b0;
      #2;
      forever begin
         clk2b = 1'b1; #10;
         clk2b = 1'b0; #10;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no completion, required finish within 1 ms");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic check_rng(input string name, input logic [31:0] act, input int lo, input int hi);
      n_tests++;
      if (((act >= lo) && (act <= hi)) !== 1'b1) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk1);
      #1;
   endtask

   // Pulses start, returns cycles from the accepted start to done (T+1 -> 1).
   task automatic measure(input int w, output int lat, output logic [11:0] res_a,
                          output logic ovf_a, output logic [3:0] res_b, output logic ovf_b,
                          output logic b_sync);
      lat = -1; res_a = '0; ovf_a = 1'b0; res_b = '0; ovf_b = 1'b0; b_sync = 1'b0;
      start = 1'b1;
      window = w[7:0];
      @(posedge clk1); #1;
      start = 1'b0;
      for (int k = 1; k <= 300 && lat < 0; k++) begin
         @(negedge clk1);
         if (k == 1) check("busy_after_start", busy_a, 1);
         if (done_a) begin
            lat = k; res_a = result_a; ovf_a = overflow_a;
            res_b = result_b; ovf_b = overflow_b; b_sync = done_b;
         end
         @(posedge clk1); #1;
      end
      @(negedge clk1);
      check("busy_after_done", busy_a, 0);
      @(posedge clk1); #1;
   endtask

   initial begin
      int          lat, nd, dl, w, t2, f, c, lo, hi;
      logic [11:0] ra;
      logic [3:0]  rb;
      logic        oa, ob, bs;

      n_tests = 0; n_fail = 0;
      rst = 1'b1; start = 1'b0; abort = 1'b0; window = '0;
      vecs[0] = '{100, 40, 1'b1, 102, 25, 1};
      vecs[1] = '{ 50, 40, 1'b0,  52,  0, 0};
      vecs[2] = '{  0, 40, 1'b0,   1,  0, 0};
      vecs[3] = '{  0, 40, 1'b1,   1,  0, 0};
      vecs[4] = '{  1, 40, 1'b0,   3,  0, 0};
      vecs[5] = '{255, 20, 1'b1, 257, 127, 1};
      vecs[6] = '{ 10, 70, 1'b1,  12,  1, 1};

      repeat (3) @(posedge clk1);
      #1;
      check("rst_busy", busy_a, 0);
      check("rst_done", done_a, 0);
      check("rst_result", result_a, 0);
      check("rst_overflow", overflow_a, 0);
      check("rst_result_b", result_b, 0);
      rst = 1'b0;
      idle(2);

      for (int i = 0; i < 7; i++) begin
         t2_half  = vecs[i].t2 / 2;
         clk2a_en = vecs[i].en;
         idle(20);
         measure(vecs[i].w, lat, ra, oa, rb, ob, bs);
         check($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
         check_rng($sformatf("vec%0d_result", i), ra,
                   vecs[i].exp_res - vecs[i].tol, vecs[i].exp_res + vecs[i].tol);
         check($sformatf("vec%0d_overflow", i), oa, 0);
         check($sformatf("vec%0d_b_done_same_cycle", i), bs, 1);
      end

      // Saturation: 4-bit counter fed at clk1/2 over 64 cycles sees 32 edges.
      t2_half = 20; clk2a_en = 1'b1;
      idle(20);
      measure(64, lat, ra, oa, rb, ob, bs);
      check("sat_latency", lat, 66);
      check("sat_result_b", rb, 15);
      check("sat_overflow_b", ob, 1);
      check_rng("sat_result_a", ra, 15, 17);

      // Abort at RUN cycle 10.
      start = 1'b1; window = 8'd100;
      @(posedge clk1); #1;
      start = 1'b0; nd = 0;
      for (int k = 1; k <= 120; k++) begin
         abort = (k == 11);
         @(negedge clk1);
         if (done_a) nd++;
         if (k == 11) check("abort_run_busy_hold", busy_a, 1);
         if (k == 12) check("abort_run_busy_low", busy_a, 0);
         @(posedge clk1); #1;
      end
      abort = 1'b0;
      check("abort_run_no_done", nd, 0);
      check("abort_run_keep_result_b", result_b, 15);
      check("abort_run_keep_overflow_b", overflow_b, 1);
      check_rng("abort_run_keep_result_a", result_a, 15, 17);

      // Abort during the DONE cycle vetoes done and keeps the old result.
      start = 1'b1; window = 8'd3;
      @(posedge clk1); #1;
      start = 1'b0; nd = 0;
      for (int k = 1; k <= 10; k++) begin
         abort = (k == 5);
         @(negedge clk1);
         if (done_a) nd++;
         if (k == 5) begin
            check("abort_done_busy", busy_a, 1);
            check("abort_done_result_b", result_b, 15);
            check("abort_done_overflow_b", overflow_b, 1);
         end
         if (k == 6) check("abort_done_busy_low", busy_a, 0);
         @(posedge clk1); #1;
      end
      abort = 1'b0;
      check("abort_done_no_done", nd, 0);

      // Abort and start together in IDLE: start is dropped.
      start = 1'b1; abort = 1'b1; window = 8'd10;
      @(posedge clk1); #1;
      start = 1'b0; abort = 1'b0; nd = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk1);
         if (busy_a) nd++;
         @(posedge clk1); #1;
      end
      check("abort_start_idle_busy_cycles", nd, 0);

      // Start re-pulsed in RUN and in DONE is ignored.
      start = 1'b1; window = 8'd20;
      @(posedge clk1); #1;
      start = 1'b0; nd = 0; dl = -1;
      for (int k = 1; k <= 40; k++) begin
         start = (k == 8) || (k == 22);
         if (start) window = 8'd5;
         @(negedge clk1);
         if (done_a) begin nd++; dl = k; end
         if (k == 23) check("restart_busy_low", busy_a, 0);
         @(posedge clk1); #1;
      end
      start = 1'b0;
      check("restart_done_count", nd, 1);
      check("restart_done_latency", dl, 22);
      check_rng("restart_result_b", result_b, 9, 11);

      // Reset mid-RUN clears everything at once; the next measurement is normal.
      start = 1'b1; window = 8'd100;
      @(posedge clk1); #1;
      start = 1'b0;
      idle(30);
      #2 rst = 1'b1;
      #1;
      check("midrst_busy", busy_a, 0);
      check("midrst_done", done_a, 0);
      check("midrst_result", result_a, 0);
      check("midrst_overflow", overflow_a, 0);
      check("midrst_result_b", result_b, 0);
      check("midrst_busy_b", busy_b, 0);
      @(posedge clk1);
      @(negedge clk1);
      rst = 1'b0;
      nd = 0;
      for (int k = 1; k <= 120; k++) begin
         @(negedge clk1);
         if (done_a) nd++;
      end
      check("midrst_no_done", nd, 0);
      idle(2);
      measure(100, lat, ra, oa, rb, ob, bs);
      check("postrst_latency", lat, 102);
      check_rng("postrst_result", ra, 24, 26);
      check("postrst_overflow", oa, 0);

      // Random windows and clk2 periods against the ideal ratio W*T1/T2 (+/-1 edge).
      for (int i = 0; i < 16; i++) begin
         w  = $urandom_range(0, 255);
         t2 = periods[$urandom_range(0, 5)];
         t2_half = t2 / 2; clk2a_en = 1'b1;
         idle(20);
         measure(w, lat, ra, oa, rb, ob, bs);
         check($sformatf("rnd%0d_latency", i), lat, (w == 0) ? 1 : w + 2);
         f  = (w * 10) / t2;
         c  = (w * 10 + t2 - 1) / t2;
         lo = (c > 0) ? c - 1 : 0;
         hi = (w == 0) ? 0 : f + 1;
         check_rng($sformatf("rnd%0d_result_a", i), ra, lo, hi);
         check($sformatf("rnd%0d_overflow_a", i), oa, 0);
         check($sformatf("rnd%0d_b_done_same_cycle", i), bs, 1);
         f  = w / 2;
         c  = (w + 1) / 2;
         lo = (c > 0) ? c - 1 : 0;
         hi = (w == 0) ? 0 : f + 1;
         if (hi <= 15) begin
            check_rng($sformatf("rnd%0d_result_b", i), rb, lo, hi);
            check($sformatf("rnd%0d_overflow_b", i), ob, 0);
         end else if (lo >= 16) begin
            check($sformatf("rnd%0d_result_b", i), rb, 15);
            check($sformatf("rnd%0d_overflow_b", i), ob, 1);
         end else begin
            check_rng($sformatf("rnd%0d_result_b", i), rb, (lo < 15) ? lo : 15, 15);
         end
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
